// File: rtl/mp_serial_adder_pkg.sv
// Shared constants for the multi-precision serial adder: state encodings and
// the width of one adder word.
package mp_serial_adder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups, each with group
// generate/propagate so the inter-group carry skips the group's bit chain.
module CLA_16bit (
    output logic        C16,
    output logic [15:0] Sum,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic        ci;
    logic        gcar;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        Sum  = '0;
        ci   = 1'b0;
        gcar = C_in;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            ci    = gcar;
            for (int j = 0; j < 4; j++) begin
                Sum[4*k+j] = p[4*k+j] ^ ci;
                ci         = g[4*k+j] | (p[4*k+j] & ci);
            end
            gcar = gg[k] | (gp[k] & gcar);
        end
        C16 = gcar;
    end

endmodule

// File: rtl/mp_serial_adder.sv
// Multi-precision add/subtract: feeds CLA_16bit one word per cycle, chaining
// the carry through a register, with valid/ready on both sides.
module mp_serial_adder
    import mp_serial_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W*WORDS-1:0] op_a,
    input  logic [WORD_W*WORDS-1:0] op_b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int W  = WORD_W * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res_reg;
    logic           carry_q;
    logic [31:0]    base;
    logic [WORD_W-1:0] sum;
    logic           c16;
    logic           accept;
    logic           last;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CW'(WORDS - 1));
    assign base     = 32'(cnt) * WORD_W;

    CLA_16bit u_cla (
        .C16  (c16),
        .Sum  (sum),
        .A    (a_reg[base +: WORD_W]),
        .B    (b_reg[base +: WORD_W]),
        .C_in (carry_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = BUSY;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            carry_q <= sub;
            cnt     <= '0;
        end else if (state == BUSY) begin
            res_reg[base +: WORD_W] <= sum;
            carry_q                 <= c16;
            if (!last) cnt <= cnt + 1'b1;
        end
    end

    // Flags only meaningful once the last word has landed.
    assign out_valid = (state == DONE);
    assign result    = res_reg;
    assign carry_out = out_valid & carry_q;
    assign overflow  = out_valid & (a_reg[W-1] == b_reg[W-1]) & (res_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_mp_serial_adder.sv
// Directed bench for mp_serial_adder (WORDS = 4): vector table plus
// backpressure and mid-operation reset sequences.
module tb_mp_serial_adder;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_chk  = 0;
    int n_fail = 0;

    mp_serial_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request with out_ready low; return edges from accept to out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready_idle", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_res;
        logic         held_c, held_ov;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 1'b1, 1'b0};

        #12;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", result, '0);
        chk("rst_carry", W'(carry_out), W'(0));
        chk("rst_overflow", W'(overflow), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), W'(lat), W'(WORDS));
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), W'(carry_out), W'(vecs[i].c));
            chk($sformatf("v%0d_overflow", i), W'(overflow), W'(vecs[i].ov));
            drain();
            chk($sformatf("v%0d_idle_valid", i), W'(out_valid), W'(0));
        end

        // Backpressure: hold DONE three cycles, then back-to-back accept.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        held_res = result; held_c = carry_out; held_ov = overflow;
        chk("bp_latency", W'(lat), W'(WORDS));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_result_hold", result, 64'h0);
            chk("bp_carry_hold", W'(carry_out), W'(1));
            chk("bp_in_ready_low", W'(in_ready), W'(0));
            chk("bp_valid_hold", W'(out_valid), W'(1));
        end
        @(negedge clk);
        op_a = 64'h1; op_b = 64'h2; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy_valid", W'(out_valid), W'(0));
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("b2b_latency", W'(lat), W'(WORDS));
        chk("b2b_result", result, 64'h3);
        chk("b2b_carry", W'(carry_out), W'(0));
        if (held_ov !== 1'b0 || held_c !== 1'b1 || held_res !== 64'h0) begin
            n_chk++; n_fail++;
            $display("FAIL bp_first_flags: got %h/%b/%b expected 0/1/0", held_res, held_c, held_ov);
        end
        drain();

        // Reset while BUSY at cnt == 2.
        @(negedge clk);
        op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'hFFFF_FFFF_FFFF_FFFF; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_result_nonzero", W'(result != '0), W'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_result", result, '0);
        chk("mid_rst_carry", W'(carry_out), W'(0));
        chk("mid_rst_overflow", W'(overflow), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        do_op(64'h3, 64'h4, 1'b0, lat);
        chk("post_rst_latency", W'(lat), W'(WORDS));
        chk("post_rst_result", result, 64'h7);
        chk("post_rst_carry", W'(carry_out), W'(0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_serial_adder.md
Name: mp_serial_adder

Overview:
- Multi-precision add/subtract engine that serially feeds the team's 16-bit carry-lookahead adder (CLA_16bit) one 16-bit word per cycle.
- Chains the carry between words through a register and assembles a WORDS×16-bit result.
- Sits directly upstream of CLA_16bit: drives its A, B and C_in, and consumes its Sum and C16.
- Valid/ready handshakes on both input and output sides.

Parameters:
- WORDS, 4, number of 16-bit words per operand (operand width W = 16*WORDS); legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  engine can accept a request this cycle.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum/difference, modulo 2^W.
- carry_out  output  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE, word counter = 0, carry register = 0, operand registers = 0.
  - result = 0, carry_out = 0, overflow = 0, out_valid = 0, in_ready = 1 once released.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: an edge with in_valid && in_ready.
  - Latch op_a into a_reg.
  - Latch b_reg = sub ? ~op_b : op_b.
  - Carry register = sub.
  - Counter = 0.
  - State → BUSY.
- BUSY, every cycle:
  - Adder inputs: A = a_reg word[cnt], B = b_reg word[cnt], C_in = carry register.
  - On the edge: result word[cnt] ← Sum, carry register ← C16.
  - At cnt == WORDS−1: state → DONE. Otherwise cnt ← cnt+1.
- DONE:
  - out_valid = 1; carry_out = carry register.
  - overflow = (a_reg MSB == b_reg MSB) && (result MSB != a_reg MSB).
  - Hold result, carry_out and overflow stable while out_valid && !out_ready.
  - out_ready high with no accept → IDLE.
  - out_ready and in_valid both high → accept the new request and go straight to BUSY (back-to-back, no bubble).
- Latency and throughput:
  - out_valid rises WORDS edges after the accept edge.
  - Throughput is one operation per WORDS+1 cycles when the consumer is always ready.
- WORDS = 1: exactly one BUSY cycle; counter is 1 bit wide and never increments.
- In BUSY, op_a, op_b, sub and in_valid are ignored (in_ready = 0).
- out_valid is low in IDLE and BUSY. result contents in BUSY are partial and undefined to the consumer.
- Reset mid-operation aborts immediately: all outputs return to reset values, with no partial result delivered.
- Wrap-around: result is truncated to W bits; the carry out of the top word appears only in carry_out.

Decomposition:
- Shared include file: state encodings (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the word width constant (16).
- Word counter width = clog2(WORDS), minimum 1, computed locally.
- One sub-module instance: the existing CLA_16bit.
  - Port order: C16, Sum, A, B, C_in.
  - Combinational; mp_serial_adder registers all of its outputs.
- Word selection uses indexed part-selects on a_reg, b_reg and result. No other sub-modules.

Test Plan (WORDS = 4):
1. Add 0x0000_0000_0000_FFFF + 0x1 → result 0x0000_0000_0001_0000, carry_out 0, overflow 0; out_valid exactly 4 cycles after accept.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → result 0, carry_out 1, overflow 0. Carry ripples through all 4 words.
3. Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 → result 0x8000_0000_0000_0000, overflow 1, carry_out 0.
4. Subtract:
   - 5 − 7 → 0xFFFF_FFFF_FFFF_FFFE, carry_out 0, overflow 0.
   - 7 − 5 → 0x2, carry_out 1.
   - 0x8000_0000_0000_0000 − 1 → 0x7FFF_FFFF_FFFF_FFFF, overflow 1.
5. Backpressure:
   - Hold out_ready low 3 cycles in DONE: result and flags stable, in_ready 0.
   - Then raise out_ready with in_valid high (op 1+2): accepted that edge; next out_valid shows 3 exactly 4 cycles later.
6. Reset mid-operation:
   - Assert rst_n low asynchronously while BUSY with cnt = 2: out_valid, result and flags go to 0 without a clock edge.
   - After release: in_ready 1, and a fresh add 3+4 returns 7.
